rtc_clock_settable: RTL and testbench
=====================================

Name: rtc_clock_settable

Overview:
Parametrised next-generation real-time clock. It keeps hours, minutes and seconds internally in 24-hour BCD and displays them on six seven-segment digits. It adds a built-in prescaler, a runtime 12/24-hour display mode with a PM flag, and a button-driven set mode with blinking of the field being edited. It sits between the board clock and button conditioning logic on one side and the six display digits on the other.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick; legal range is 2 and above.
SEG_ACTIVE_LOW, 0, when 1 all segment outputs are inverted (common-anode board).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display; sampled every cycle
btn_mode  in  1  single-cycle pulse, already debounced and synchronised; advances the set FSM
btn_inc  in  1  single-cycle pulse, already debounced and synchronised; increments the field being set
S_L, S_M, M_L, M_M, H_L, H_M  out  7 each  segment digits, bit order {g,f,e,d,c,b,a}
pm  out  1  1 when internal hour >= 12; valid in both display modes
sec_tick  out  1  one-cycle pulse on each seconds advance
setting  out  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN

Behaviour:
- Reset (synchronous, any state):
  - Time 00:00:00, FSM RUN, prescaler 0, sec_tick 0, setting 00.
  - Display shows 00:00:00 in 24-hour mode and 12:00:00 in 12-hour mode; pm 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted in the cycle where count == TICK_DIV-1.
- RUN state:
  - On tick: seconds +1, registered on the next clk edge; sec_tick is high for that same one cycle.
  - Carry chain: 59 s -> 0 with minutes +1; 59 min -> 0 with hours +1; 23 h -> 0.
  - 23:59:59 wraps to 00:00:00 in a single edge.
  - btn_inc is ignored.
- Set FSM:
  - RUN --btn_mode--> SET_HR --btn_mode--> SET_MIN --btn_mode--> RUN.
  - Entering SET_HR: prescaler is cleared to 0. The prescaler keeps running for blink timing, but time does not advance and sec_tick stays 0.
  - SET_HR: btn_inc sets hours to (hours+1) mod 24; no carry into other fields.
  - SET_MIN: btn_inc sets minutes to (minutes+1) mod 60; no carry into hours. Seconds are held.
  - Leaving SET_MIN for RUN: seconds cleared to 00 and prescaler cleared to 0, so the first tick occurs TICK_DIV cycles later.
  - btn_mode and btn_inc in the same cycle: btn_mode wins and btn_inc is dropped.
- Blink:
  - In SET_HR, H_L and H_M are blanked while prescaler count >= TICK_DIV/2 (integer division).
  - In SET_MIN, M_L and M_M are blanked under the same condition.
  - Blank = all segments inactive.
- Display mapping (combinational from registered state, zero added latency):
  - 24-hour mode: digits are the stored BCD.
  - 12-hour mode, display hour: 0 -> 12; 1..12 -> unchanged; 13..23 -> h-12.
  - 12-hour mode shows a leading zero: 01..09 display as 0,1..0,9.
  - pm = (hour >= 12) regardless of mode_12h.
  - Toggling mode_12h affects only the display; stored time is unchanged.
- Segment encoding, active-high, bit order {g,f,e,d,c,b,a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Codes 10-15 decode to blank.
  - SEG_ACTIVE_LOW inverts the final output, including blanks.
- Reset mid-set returns to RUN with 00:00:00, regardless of the value being edited.
- Arithmetic: every field is stored as two BCD nibbles. Tens digits are limited to 0-5 for seconds and minutes, and 0-2 for hours.

Decomposition:
- Shared package rtc_pkg:
  - FSM state enum: RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10.
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - Field limits MAX_SEC = 59, MAX_MIN = 59, MAX_HR = 23.
  - A bcd_to_seg function.
- One natural sub-module, bcd_mod_counter:
  - Two-digit BCD counter with parameter MAX, inputs inc and clr, output carry.
  - Instantiated three times (sec, min, hr).
  - carry is asserted combinationally when inc is high and the value is MAX.

Test Plan (TICK_DIV = 4):
- Reset, then 12 cycles in RUN -> sec_tick pulses at cycles 4, 8 and 12; S_L shows 1, 2, 3 (1011011 for 2); pm 0.
- Preload 23:59:58 via set mode, run 8 cycles -> display 00:00:00, all digits 0111111, pm drops from 1 to 0.
- Hour 13, toggle mode_12h 0->1 -> H_M:H_L change from 1:3 to 0:1 with pm 1; hour 0 in 12-hour mode -> displays 1:2 with pm 0.
- btn_mode, then btn_inc x25 -> hour 01 (wraps mod 24), minutes and seconds unchanged, no sec_tick. Hours blanked at count 2-3 and visible at count 0-1.
- In SET_MIN at 00:59, btn_inc -> 00:00 with hours unchanged. btn_mode and btn_inc together -> RUN, minutes unchanged, seconds 00, next sec_tick exactly 4 cycles later.
- Assert rst during SET_MIN -> next cycle setting 00, time 00:00:00. Repeat with SEG_ACTIVE_LOW = 1 -> digit 0 reads 1000000.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, segment codes and field limits for the settable real-time clock.
package rtc_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } rtc_state_e;

   // Segment bit order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam int MAX_SEC = 59;
   localparam int MAX_MIN = 59;
   localparam int MAX_HR  = 23;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/rtc_clock_settable_bcd_mod_counter.sv
// Two-digit BCD modulo counter; wraps to 00 after MAX and flags carry on that increment.
module bcd_mod_counter #(
   parameter int MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] val,
   output logic       carry
);

   localparam logic [3:0] MAX_T = 4'(MAX / 10);
   localparam logic [3:0] MAX_O = 4'(MAX % 10);

   logic [7:0] val_q;
   logic [7:0] val_d;
   logic       at_max;

   always_comb begin
      at_max = (val_q[7:4] == MAX_T) && (val_q[3:0] == MAX_O);
      carry  = inc && at_max;
      val_d  = val_q;
      if (clr) begin
         val_d = 8'h00;
      end else if (inc) begin
         if (at_max)
            val_d = 8'h00;
         else if (val_q[3:0] == 4'd9)
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         else
            val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         val_q <= 8'h00;
      else
         val_q <= val_d;
   end

   assign val = val_q;

endmodule

// File: rtl/rtc_clock_settable.sv
// Settable BCD real-time clock with prescaler, 12/24-hour display and blinking set mode.
//   state   | meaning
//   RUN     | time advances once per prescaler wrap, buttons other than mode ignored
//   SET_HR  | time frozen, btn_inc bumps hours mod 24, hour digits blink
//   SET_MIN | time frozen, btn_inc bumps minutes mod 60, minute digits blink
module rtc_clock_settable
   import rtc_pkg::*;
#(
   parameter int TICK_DIV       = 50000000,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_12h,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [6:0] S_L,
   output logic [6:0] S_M,
   output logic [6:0] M_L,
   output logic [6:0] M_M,
   output logic [6:0] H_L,
   output logic [6:0] H_M,
   output logic       pm,
   output logic       sec_tick,
   output logic [1:0] setting
);

   localparam int             CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  CNT_HALF  = CW'(TICK_DIV / 2);

   rtc_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sec_tick_q, sec_tick_d;

   logic tick;
   logic cnt_clr, sec_clr, sec_inc, min_inc_set, hr_inc_set;
   logic min_inc, hr_inc;
   logic sec_carry, min_carry, hr_carry_unused;
   logic [7:0] sec_val, min_val, hr_val;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_clr     = 1'b0;
      sec_clr     = 1'b0;
      sec_inc     = 1'b0;
      min_inc_set = 1'b0;
      hr_inc_set  = 1'b0;
      case (state_q)
         RUN: begin
            sec_inc = tick;
            if (btn_mode) begin
               state_d = SET_HR;
               cnt_clr = 1'b1;
            end
         end
         SET_HR: begin
            if (btn_mode)
               state_d = SET_MIN;
            else if (btn_inc)
               hr_inc_set = 1'b1;
         end
         SET_MIN: begin
            // Leaving set mode restarts the second from zero.
            if (btn_mode) begin
               state_d = RUN;
               sec_clr = 1'b1;
               cnt_clr = 1'b1;
            end else if (btn_inc) begin
               min_inc_set = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
      cnt_d      = (cnt_clr || tick) ? '0 : cnt_q + 1'b1;
      sec_tick_d = sec_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         sec_tick_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sec_tick_q <= sec_tick_d;
      end
   end

   // Minute carries only ripple into hours while running, never from a manual edit.
   assign min_inc = sec_carry || min_inc_set;
   assign hr_inc  = ((state_q == RUN) && min_carry) || hr_inc_set;

   bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc),
      .clr   (sec_clr),
      .val   (sec_val),
      .carry (sec_carry)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (min_inc),
      .clr   (1'b0),
      .val   (min_val),
      .carry (min_carry)
   );

   bcd_mod_counter #(.MAX(MAX_HR)) u_hr (
      .clk   (clk),
      .rst   (rst),
      .inc   (hr_inc),
      .clr   (1'b0),
      .val   (hr_val),
      .carry (hr_carry_unused)
   );

   logic [4:0] hr_bin, disp_bin;
   logic [7:0] hr_disp;
   logic       blink_off, blank_hr, blank_min;

   always_comb begin
      hr_bin = 5'(hr_val[7:4]) * 5'd10 + 5'(hr_val[3:0]);
      if (hr_bin == 5'd0)
         disp_bin = 5'd12;
      else if (hr_bin > 5'd12)
         disp_bin = hr_bin - 5'd12;
      else
         disp_bin = hr_bin;
      if (!mode_12h)
         hr_disp = hr_val;
      else if (disp_bin >= 5'd10)
         hr_disp = {4'd1, 4'(disp_bin - 5'd10)};
      else
         hr_disp = {4'd0, 4'(disp_bin)};
   end

   assign blink_off = (cnt_q >= CNT_HALF);
   assign blank_hr  = (state_q == SET_HR) && blink_off;
   assign blank_min = (state_q == SET_MIN) && blink_off;

   function automatic logic [6:0] drive_seg(input logic [3:0] d, input logic blank);
      logic [6:0] s;
      s = blank ? SEG_BLANK : bcd_to_seg(d);
      return SEG_ACTIVE_LOW ? ~s : s;
   endfunction

   assign S_L      = drive_seg(sec_val[3:0], 1'b0);
   assign S_M      = drive_seg(sec_val[7:4], 1'b0);
   assign M_L      = drive_seg(min_val[3:0], blank_min);
   assign M_M      = drive_seg(min_val[7:4], blank_min);
   assign H_L      = drive_seg(hr_disp[3:0], blank_hr);
   assign H_M      = drive_seg(hr_disp[7:4], blank_hr);
   assign pm       = (hr_bin >= 5'd12);
   assign sec_tick = sec_tick_q;
   assign setting  = state_q;

endmodule

// File: tb/tb_rtc_clock_settable.sv
// Scoreboard bench for rtc_clock_settable with TICK_DIV = 4, plus a common-anode instance.
module tb_rtc_clock_settable;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mode_12h = 1'b0;
   logic btn_mode = 1'b0;
   logic btn_inc = 1'b0;

   logic [6:0] s_l, s_m, m_l, m_m, h_l, h_m;
   logic       pm, sec_tick;
   logic [1:0] setting;
   logic [6:0] s_l_al, s_m_al, m_l_al, m_m_al, h_l_al, h_m_al;
   logic       pm_al, sec_tick_al;
   logic [1:0] setting_al;

   always #5 clk = ~clk;

   rtc_clock_settable #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .mode_12h(mode_12h), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .S_L(s_l), .S_M(s_m), .M_L(m_l), .M_M(m_m), .H_L(h_l), .H_M(h_m),
      .pm(pm), .sec_tick(sec_tick), .setting(setting)
   );

   rtc_clock_settable #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .mode_12h(mode_12h), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .S_L(s_l_al), .S_M(s_m_al), .M_L(m_l_al), .M_M(m_m_al), .H_L(h_l_al), .H_M(h_m_al),
      .pm(pm_al), .sec_tick(sec_tick_al), .setting(setting_al)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [23:0] dig;   // {H_M,H_L,M_M,M_L,S_M,S_L}, 4'hF = blank
      logic        pm;
      logic [1:0]  set;
   } disp_t;

   typedef struct {
      int         at;
      logic [3:0] sl;
   } tick_t;

   disp_t dq[$];
   tick_t tq[$];

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [41:0] segs_of(input logic [23:0] dig);
      return {seg_of(dig[23:20]), seg_of(dig[19:16]), seg_of(dig[15:12]),
              seg_of(dig[11:8]), seg_of(dig[7:4]), seg_of(dig[3:0])};
   endfunction

   disp_t       me;
   tick_t       mt;
   logic [44:0] m_act, m_exp;
   logic [41:0] m_act_al, m_exp_al;

   always @(negedge clk) begin
      while (dq.size() > 0) begin
         me = dq.pop_front();
         m_act = {h_m, h_l, m_m, m_l, s_m, s_l, pm, setting};
         m_exp = {segs_of(me.dig), me.pm, me.set};
         checks++;
         if (m_act !== m_exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", me.name, m_act, m_exp);
         end
         m_act_al = {h_m_al, h_l_al, m_m_al, m_l_al, s_m_al, s_l_al};
         m_exp_al = ~segs_of(me.dig);
         checks++;
         if (m_act_al !== m_exp_al) begin
            errors++;
            $display("FAIL %s_active_low: got %h want %h", me.name, m_act_al, m_exp_al);
         end
      end
      if (sec_tick === 1'b1) begin
         checks++;
         if (tq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sec_tick: got tick at cycle %0d want none", cyc);
         end else begin
            mt = tq.pop_front();
            if (cyc != mt.at || s_l !== seg_of(mt.sl)) begin
               errors++;
               $display("FAIL sec_tick: got cycle %0d S_L %b want cycle %0d S_L %b",
                        cyc, s_l, mt.at, seg_of(mt.sl));
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_mode();
      btn_mode = 1'b1;
      @(posedge clk); #1;
      btn_mode = 1'b0;
   endtask

   task automatic pulse_inc(input int n);
      repeat (n) begin
         btn_inc = 1'b1;
         @(posedge clk); #1;
         btn_inc = 1'b0;
      end
   endtask

   task automatic chk(input string nm, input logic [23:0] dig, input logic p, input logic [1:0] s);
      dq.push_back('{nm, dig, p, s});
      @(negedge clk); #1;
   endtask

   task automatic exp_tick(input int at, input logic [3:0] sl);
      tq.push_back('{at, sl});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   int base;

   initial begin
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      base = cyc;
      exp_tick(base + 4, 4'd1);
      exp_tick(base + 8, 4'd2);
      exp_tick(base + 12, 4'd3);
      chk("reset_24h", 24'h000000, 1'b0, 2'b00);
      mode_12h = 1'b1;
      chk("reset_12h", 24'h120000, 1'b0, 2'b00);
      mode_12h = 1'b0;
      step(11);
      chk("run_3s", 24'h000003, 1'b0, 2'b00);

      // preload 23:59 then run 58 s to reach 23:59:58, then across midnight
      pulse_mode();
      pulse_inc(23);
      pulse_mode();
      pulse_inc(59);
      pulse_mode();
      base = cyc;
      for (int k = 1; k <= 60; k++) exp_tick(base + 4 * k, 4'(k % 10));
      step(232);
      chk("pre_wrap", 24'h235958, 1'b1, 2'b00);
      step(8);
      chk("wrap_midnight", 24'h000000, 1'b0, 2'b00);

      // hour 13 in both display modes
      pulse_mode();
      pulse_inc(13);
      pulse_mode();
      pulse_mode();
      chk("h13_24h", 24'h130000, 1'b1, 2'b00);
      mode_12h = 1'b1;
      chk("h13_12h", 24'h010000, 1'b1, 2'b00);
      pulse_mode();
      pulse_inc(11);
      pulse_mode();
      pulse_mode();
      base = cyc;
      chk("h0_12h", 24'h120000, 1'b0, 2'b00);
      mode_12h = 1'b0;
      exp_tick(base + 4, 4'd1);
      exp_tick(base + 8, 4'd2);
      exp_tick(base + 12, 4'd3);
      step(13);

      // 25 increments wrap hours to 01; blink follows the prescaler
      pulse_mode();
      pulse_inc(25);
      chk("hr_wrap25", 24'h010003, 1'b0, 2'b01);
      step(1);
      chk("hr_blink_c2", 24'hFF0003, 1'b0, 2'b01);
      step(1);
      chk("hr_blink_c3", 24'hFF0003, 1'b0, 2'b01);
      step(1);
      chk("hr_visible_c0", 24'h010003, 1'b0, 2'b01);

      pulse_mode();
      pulse_inc(59);
      chk("min59", 24'h015903, 1'b0, 2'b10);
      pulse_inc(1);
      chk("min_wrap_no_carry", 24'h010003, 1'b0, 2'b10);
      step(1);
      chk("min_blink", 24'h01FF03, 1'b0, 2'b10);

      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      @(posedge clk); #1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      base = cyc;
      exp_tick(base + 4, 4'd1);
      chk("mode_wins", 24'h010000, 1'b0, 2'b00);
      step(4);

      // reset while editing minutes
      pulse_mode();
      pulse_inc(2);
      pulse_mode();
      pulse_inc(1);
      chk("pre_rst", 24'h030101, 1'b0, 2'b10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_in_set", 24'h000000, 1'b0, 2'b00);
      checks++;
      if (s_l_al !== 7'b1000000) begin
         errors++;
         $display("FAIL active_low_zero: got %b want %b", s_l_al, 7'b1000000);
      end
      checks++;
      if (tq.size() != 0) begin
         errors++;
         $display("FAIL missing_sec_ticks: got %0d pending want 0", tq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
